// File: rtl/riscv_pkg.sv
// Shared core constants, FSM state type and offset sign extension
// for the program-counter stage.
package riscv_pkg;

  localparam int PC_W  = 16;
  localparam int OFF_W = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-side branch request and fetch-side PC results for pc_sequencer.
interface pc_sequencer_if #(
  parameter int PC_W  = 16,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             br_valid;
  logic [PC_W-1:0]  br_pc;
  logic [OFF_W-1:0] br_offset;
  logic             bcc;
  logic             bcs;
  logic             bne;
  logic             beq;
  logic             bal;
  logic [PC_W-1:0]  pc_out;
  logic             pc_valid;
  logic             flush;
  logic [PC_W-1:0]  lr_out;
  logic             lr_we;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output stall, br_valid, br_pc, br_offset, bcc, bcs, bne, beq, bal,
    input  pc_out, pc_valid, flush, lr_out, lr_we, taken_cnt
  );

  modport slave (
    input  stall, br_valid, br_pc, br_offset, bcc, bcs, bne, beq, bal,
    output pc_out, pc_valid, flush, lr_out, lr_we, taken_cnt
  );
endinterface

// File: rtl/branch_target_adder.sv
// PC-relative target: base plus sign-extended word offset, modulo 2^PC_W.
module branch_target_adder #(
  parameter int PC_W  = 16,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  base,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  target
);
  assign target = base + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
endmodule

// File: rtl/pc_sequencer.sv
// PC redirect stage: accepts taken branches, loads the target, holds a
// fixed-length flush, updates the link register and counts redirects.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter int              PC_W         = riscv_pkg::PC_W,
  parameter int              OFF_W        = riscv_pkg::OFF_W,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input logic          clk,
  input logic          rst_n,
  pc_sequencer_if.slave bus
);

  state_t           state, state_nx;
  logic [2:0]       fcnt, fcnt_nx;
  logic [PC_W-1:0]  pc, pc_nx;
  logic             pc_valid, pc_valid_nx;
  logic             flush, flush_nx;
  logic [PC_W-1:0]  lr, lr_nx;
  logic             lr_we, lr_we_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [PC_W-1:0]  target;
  logic             taken;

  branch_target_adder #(.PC_W(PC_W), .OFF_W(OFF_W)) u_target (
    .base   (bus.br_pc),
    .offset (bus.br_offset),
    .target (target)
  );

  assign taken = bus.br_valid & (bus.bcc | bus.bcs | bus.bne | bus.beq | bus.bal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fcnt     <= '0;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      lr       <= '0;
      lr_we    <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      fcnt     <= fcnt_nx;
      pc       <= pc_nx;
      pc_valid <= pc_valid_nx;
      flush    <= flush_nx;
      lr       <= lr_nx;
      lr_we    <= lr_we_nx;
      cnt      <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    fcnt_nx     = fcnt;
    pc_nx       = pc;
    pc_valid_nx = pc_valid;
    flush_nx    = flush;
    lr_nx       = lr;
    lr_we_nx    = 1'b0;
    cnt_nx      = cnt;
    case (state)
      RUN: begin
        // pc_valid low in RUN only happens straight out of reset: present
        // RESET_PC as the first fetch address before advancing.
        if (!pc_valid) begin
          pc_valid_nx = 1'b1;
        end else if (!bus.stall) begin
          if (taken) begin
            pc_nx       = target;
            flush_nx    = 1'b1;
            pc_valid_nx = 1'b0;
            fcnt_nx     = 3'(FLUSH_CYCLES - 1);
            state_nx    = FLUSH;
            if (cnt != '1) cnt_nx = cnt + CNT_W'(1);
            if (bus.bal) begin
              lr_nx    = bus.br_pc + PC_W'(1);
              lr_we_nx = 1'b1;
            end
          end else begin
            pc_nx = pc + PC_W'(1);
          end
        end
      end
      FLUSH: begin
        if (fcnt != 3'd0) begin
          fcnt_nx = fcnt - 3'd1;
        end else begin
          state_nx    = RUN;
          flush_nx    = 1'b0;
          pc_valid_nx = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign bus.pc_out    = pc;
  assign bus.pc_valid  = pc_valid;
  assign bus.flush     = flush;
  assign bus.lr_out    = lr;
  assign bus.lr_we     = lr_we;
  assign bus.taken_cnt = cnt;

endmodule
